scaler_h: RTL and testbench

- Horizontal bicubic (Catmull-Rom, a = -0.5) down-scaler.
- Sits directly downstream of the vertical scaler `scaler_v` and consumes its do/de/hs/vs stream unchanged.
- Produces the final scaled stream for the monitor/output path, with the same pulse conventions.
- Streaming only, no line buffer: supports 1:1 and down-scaling up to 4:1.

---
 rtl/scaler_pkg.sv | 32 +++
 rtl/scaler_cubic_coe.sv | 62 ++++++
 rtl/scaler_h.sv | 197 +++++++++++++++++++
 tb/tb_scaler_h.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared types and constants for the horizontal/vertical scaler family.
package scaler_pkg;

  // Default fractional width of phase and coefficients, and default pixel width.
  localparam int COE_W = 8;
  localparam int PIX_W = 8;

  // Coefficient: signed, two integer bits above the COE_W fraction (covers -0.07..1.0).
  localparam int COE_T_W = COE_W + 2;
  // Product of a coefficient and a zero-extended pixel.
  localparam int PROD_W  = COE_T_W + PIX_W + 1;
  // Sum of four products.
  localparam int SUM_W   = PROD_W + 2;

  // Cycles from emission decision to de_o/do_o, also the hs/vs delay.
  localparam int PIPE_LAT = 4;

  typedef logic signed [COE_T_W-1:0] coe_t;
  typedef logic signed [PROD_W-1:0]  prod_t;
  typedef logic signed [SUM_W-1:0]   sum_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Returns log2(value) when value is a power of two, otherwise -1.
  function automatic int clog2_pow2(input int value);
    for (int i = 0; i < 31; i++) begin
      if (value == (1 << i)) return i;
    end
    return -1;
  endfunction

endpackage

// File: rtl/scaler_cubic_coe.sv
// Catmull-Rom (a = -0.5) weights for phase t, registered.
// w-1 and w2 are rounded; w1 and w0 are derived so that the weights sum to
// exactly 1.0 and reproduce a linear ramp exactly (first moment equals t).
module scaler_cubic_coe
  import scaler_pkg::*;
#(
  parameter int COE_WIDTH = COE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COE_WIDTH-1:0] t,
  output coe_t                 w_m1,
  output coe_t                 w_0,
  output coe_t                 w_1,
  output coe_t                 w_2
);

  localparam int AW = 3 * COE_WIDTH + 6;
  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t HALF = acc_t'(1) << (2 * COE_WIDTH);
  localparam coe_t ONE  = coe_t'(1 << COE_WIDTH);

  acc_t tt;
  acc_t t2;
  acc_t t3;
  acc_t num_m1;
  acc_t num_2;
  coe_t c_m1;
  coe_t c_0;
  coe_t c_1;
  coe_t c_2;

  // Polynomial evaluation in integer form scaled by 2^(3*COE_WIDTH+1).
  always_comb begin
    tt     = acc_t'(t);
    t2     = tt * tt;
    t3     = t2 * tt;
    num_m1 = (t2 <<< (COE_WIDTH + 1)) - t3 - (tt <<< (2 * COE_WIDTH));
    num_2  = t3 - (t2 <<< COE_WIDTH);
    c_m1   = coe_t'((num_m1 + HALF) >>> (2 * COE_WIDTH + 1));
    c_2    = coe_t'((num_2 + HALF) >>> (2 * COE_WIDTH + 1));
    c_1    = coe_t'(tt) + c_m1 - (c_2 <<< 1);
    c_0    = ONE - c_m1 - c_1 - c_2;
  end

  // Register the weights so the next stage sees them one cycle after t.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_m1 <= '0;
      w_0  <= '0;
      w_1  <= '0;
      w_2  <= '0;
    end else begin
      w_m1 <= c_m1;
      w_0  <= c_0;
      w_1  <= c_1;
      w_2  <= c_2;
    end
  end

endmodule

// File: rtl/scaler_h.sv
// Streaming horizontal bicubic down-scaler (1:1 .. 4:1), no line buffer.
// A 4-tap window follows the input; an output is emitted when its rightmost
// tap arrives, and two replicated-tap cycles after the last pixel flush the tail.
module scaler_h
  import scaler_pkg::*;
#(
  parameter int LINE_IN_SIZE_MAX = 1024,
  parameter int LINE_STEP        = 128,
  parameter int PIXEL_WIDTH      = PIX_W,
  parameter int COE_WIDTH        = COE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            line_in_size,
  input  logic [15:0]            scale_step,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam int FRAC    = clog2_pow2(LINE_STEP);
  localparam int CNT_W   = $clog2(LINE_IN_SIZE_MAX) + 2;
  localparam int POS_W   = CNT_W + FRAC;
  localparam int STEP_W  = FRAC + 3;
  localparam int PIX_MAX = (1 << PIXEL_WIDTH) - 1;

  localparam logic [CNT_W-1:0]  LAST_MAX = CNT_W'(LINE_IN_SIZE_MAX - 1);
  localparam logic [STEP_W-1:0] STEP_MIN = STEP_W'(LINE_STEP);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(4 * LINE_STEP);

  if (COE_WIDTH != COE_W || PIXEL_WIDTH != PIX_W || FRAC < 1 || FRAC > COE_WIDTH) begin : g_bad_cfg
    $error("scaler_h: LINE_STEP must be a power of two in [2, 2^COE_WIDTH]; widths must match scaler_pkg");
  end

  state_t                  state;
  logic [CNT_W-1:0]        n;
  logic [CNT_W-1:0]        last;
  logic [POS_W-1:0]        pos;
  logic [STEP_W-1:0]       step;
  logic [PIXEL_WIDTH-1:0]  taps   [4];
  logic [PIXEL_WIDTH-1:0]  tap_nx [4];

  logic [STEP_W-1:0]       step_cfg;
  logic [CNT_W-1:0]        last_cfg;
  logic [CNT_W-1:0]        pi;
  logic [POS_W-1:0]        last_pos;
  logic                    adv;
  logic                    emit;
  logic [PIXEL_WIDTH-1:0]  din;
  logic [COE_WIDTH-1:0]    t_nx;

  logic                    v0;
  logic [COE_WIDTH-1:0]    t0;
  logic [PIXEL_WIDTH-1:0]  win0 [4];
  logic                    v1;
  logic [PIXEL_WIDTH-1:0]  win1 [4];
  coe_t                    w    [4];
  logic                    v2;
  prod_t                   prod [4];
  sum_t                    sum;
  sum_t                    rounded;
  logic [PIXEL_WIDTH-1:0]  pix_out;
  logic [PIPE_LAT-1:0]     hs_d;
  logic [PIPE_LAT-1:0]     vs_d;

  assign pi       = pos[POS_W-1:FRAC];
  assign last_pos = {last, {FRAC{1'b0}}};

  // Line configuration as it would be latched on hs_i: clamped step and last index.
  always_comb begin
    if (scale_step < 16'(LINE_STEP))          step_cfg = STEP_MIN;
    else if (scale_step > 16'(4 * LINE_STEP)) step_cfg = STEP_MAX;
    else                                      step_cfg = STEP_W'(scale_step);
    if (line_in_size > 16'(LINE_IN_SIZE_MAX - 1)) last_cfg = LAST_MAX;
    else                                          last_cfg = CNT_W'(line_in_size);
  end

  // Window advance and emission decision; FLUSH feeds the last pixel back in.
  always_comb begin
    adv = 1'b0;
    if (!hs_i) begin
      if (state == RUN)        adv = de_i;
      else if (state == FLUSH) adv = 1'b1;
    end
    din = (state == FLUSH) ? taps[3] : di_i;
    if (n == '0) begin
      for (int i = 0; i < 4; i++) tap_nx[i] = din;
    end else begin
      tap_nx[0] = taps[1];
      tap_nx[1] = taps[2];
      tap_nx[2] = taps[3];
      tap_nx[3] = din;
    end
    emit = adv && (pi + CNT_W'(2) == n) && (pos <= last_pos);
    t_nx = COE_WIDTH'(pos[FRAC-1:0]) << (COE_WIDTH - FRAC);
  end

  // Line FSM, position accumulator, window and the emission stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      last  <= '0;
      pos   <= '0;
      step  <= STEP_MIN;
      v0    <= 1'b0;
      t0    <= '0;
      for (int i = 0; i < 4; i++) begin
        taps[i] <= '0;
        win0[i] <= '0;
      end
    end else begin
      v0 <= emit;
      if (emit) begin
        t0 <= t_nx;
        for (int i = 0; i < 4; i++) win0[i] <= tap_nx[i];
      end
      if (hs_i) begin
        state <= RUN;
        n     <= '0;
        pos   <= '0;
        step  <= step_cfg;
        last  <= last_cfg;
      end else if (adv) begin
        for (int i = 0; i < 4; i++) taps[i] <= tap_nx[i];
        n <= n + CNT_W'(1);
        if (emit) pos <= pos + POS_W'(step);
        if (state == RUN && n == last)                       state <= FLUSH;
        else if (state == FLUSH && n == last + CNT_W'(2))    state <= IDLE;
      end
    end
  end

  scaler_cubic_coe #(
    .COE_WIDTH (COE_WIDTH)
  ) u_coe (
    .clk  (clk),
    .rst  (rst),
    .t    (t0),
    .w_m1 (w[0]),
    .w_0  (w[1]),
    .w_1  (w[2]),
    .w_2  (w[3])
  );

  // Keep the window aligned with the weights, then form the four products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        win1[i] <= '0;
        prod[i] <= '0;
      end
    end else begin
      v1 <= v0;
      v2 <= v1;
      for (int i = 0; i < 4; i++) begin
        win1[i] <= win0[i];
        prod[i] <= prod_t'(w[i]) * prod_t'($signed({1'b0, win1[i]}));
      end
    end
  end

  // Sum, round half-up and clamp to the pixel range.
  always_comb begin
    sum     = sum_t'(prod[0]) + sum_t'(prod[1]) + sum_t'(prod[2]) + sum_t'(prod[3]);
    rounded = (sum + sum_t'(1 << (COE_WIDTH - 1))) >>> COE_WIDTH;
    if (rounded[SUM_W-1])                  pix_out = '0;
    else if (rounded > sum_t'(PIX_MAX))    pix_out = PIXEL_WIDTH'(PIX_MAX);
    else                                   pix_out = PIXEL_WIDTH'(rounded);
  end

  // Output register plus the matching hs/vs delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_o <= '0;
      de_o <= 1'b0;
      hs_d <= '0;
      vs_d <= '0;
    end else begin
      do_o <= v2 ? pix_out : '0;
      de_o <= v2;
      hs_d <= {hs_d[PIPE_LAT-2:0], hs_i};
      vs_d <= {vs_d[PIPE_LAT-2:0], vs_i & hs_i};
    end
  end

  assign hs_o = hs_d[PIPE_LAT-1];
  assign vs_o = vs_d[PIPE_LAT-1];

endmodule

// File: tb/tb_scaler_h.sv
// Self-checking bench for scaler_h: table of ramp lines plus hand sequences.
module tb_scaler_h;

  typedef struct {
    string name;
    int    scale_step;
    int    step_eff;
    int    gap;
    int    vs;
    int    exp_count;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] line_in_size = '0;
  logic [15:0] scale_step = '0;
  logic [7:0]  di_i = '0;
  logic        de_i = 1'b0;
  logic        hs_i = 1'b0;
  logic        vs_i = 1'b0;
  logic [7:0]  do_o;
  logic        de_o;
  logic        hs_o;
  logic        vs_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_drive_cyc = 0;
  int out_q[$];
  int hs_cyc_q[$];
  int hs_mark_q[$];
  int vs_cyc_q[$];
  vec_t vecs[5];

  scaler_h dut (
    .clk          (clk),
    .rst          (rst),
    .line_in_size (line_in_size),
    .scale_step   (scale_step),
    .di_i         (di_i),
    .de_i         (de_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .do_o         (do_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure hs/vs latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (hs_o) begin
      hs_cyc_q.push_back(cyc);
      hs_mark_q.push_back(out_q.size());
    end
    if (vs_o) vs_cyc_q.push_back(cyc);
    if (de_o) out_q.push_back(int'(do_o));
  end

  function automatic vec_t make_vec(string name, int ss, int se, int gap, int vs, int cnt);
    vec_t v;
    v.name = name; v.scale_step = ss; v.step_eff = se;
    v.gap = gap; v.vs = vs; v.exp_count = cnt;
    return v;
  endfunction

  function automatic int pix(int kind, int x);
    if (kind == 0) return (x + 1) % 256;
    return (x == 0 || x == 3 || x == 8) ? 255 : 0;
  endfunction

  // Expected output k of a ramp line; -1 where edge replication breaks linearity.
  function automatic int ramp_expect(int step, int k);
    int pos, pi, f;
    pos = k * step;
    pi  = pos / 128;
    f   = pos % 128;
    if (f == 0) return (pi + 1) % 256;
    if (pi >= 1 && pi + 2 <= 254) return (pos + 192) / 128;
    return -1;
  endfunction

  function automatic int q_at(int k);
    if (k >= 0 && k < out_q.size()) return out_q[k];
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    out_q.delete();
    hs_cyc_q.delete();
    hs_mark_q.delete();
    vs_cyc_q.delete();
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int last_idx, input int step, input int gap,
                                input int vs, input int npix, input int kind);
    line_in_size = 16'(last_idx);
    scale_step   = 16'(step);
    hs_i = 1'b1;
    vs_i = vs[0];
    hs_drive_cyc = cyc;
    tick();
    hs_i = 1'b0;
    vs_i = 1'b0;
    for (int x = 0; x < npix; x++) begin
      di_i = 8'(pix(kind, x));
      de_i = 1'b1;
      tick();
      de_i = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic check_ramp_line(input string name, input int base, input int step, input int cnt);
    int e;
    check_output({name, " count"}, out_q.size() - base, cnt);
    for (int k = 0; k < cnt; k++) begin
      e = ramp_expect(step, k);
      if (e >= 0) check_output($sformatf("%s[%0d]", name, k), q_at(base + k), e);
    end
  endtask

  task automatic run_ramp(input vec_t v);
    clear_q();
    apply_stimulus(255, v.scale_step, v.gap, v.vs, 256, 0);
    repeat (12) tick();
    check_output({v.name, " hs count"}, hs_cyc_q.size(), 1);
    if (hs_cyc_q.size() > 0)
      check_output({v.name, " hs latency"}, hs_cyc_q[0] - hs_drive_cyc, 4);
    check_output({v.name, " vs count"}, vs_cyc_q.size(), v.vs);
    if (v.vs != 0 && vs_cyc_q.size() > 0 && hs_cyc_q.size() > 0)
      check_output({v.name, " vs with hs"}, vs_cyc_q[0], hs_cyc_q[0]);
    check_ramp_line(v.name, 0, v.step_eff, v.exp_count);
  endtask

  task automatic check_idle_outputs(input string name);
    check_output({name, " do_o"}, int'(do_o), 0);
    check_output({name, " de_o"}, int'(de_o), 0);
    check_output({name, " hs_o"}, int'(hs_o), 0);
    check_output({name, " vs_o"}, int'(vs_o), 0);
  endtask

  initial begin
    vecs[0] = make_vec("identity", 128, 128, 0, 0, 256);
    vecs[1] = make_vec("down2",    256, 256, 0, 1, 128);
    vecs[2] = make_vec("down1p5",  192, 192, 0, 0, 171);
    vecs[3] = make_vec("sparse2",  256, 256, 3, 0, 128);
    vecs[4] = make_vec("step64",    64, 128, 0, 0, 256);

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) tick();

    // vs_i without hs_i must not start a line or produce vs_o.
    clear_q();
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    repeat (8) tick();
    check_output("lone vs vs_o", vs_cyc_q.size(), 0);
    check_output("lone vs hs_o", hs_cyc_q.size(), 0);
    check_output("lone vs de_o", out_q.size(), 0);

    // Table-driven ramp lines.
    for (int i = 0; i < 5; i++) run_ramp(vecs[i]);

    // Clamp: negative lobe at t=0.5 clamps to 0; 0,0,255,0 window gives 143.
    clear_q();
    apply_stimulus(15, 192, 0, 0, 16, 1);
    repeat (12) tick();
    check_output("clamp count", out_q.size(), 11);
    check_output("clamp[0]", q_at(0), 255);
    check_output("clamp[1]", q_at(1), 0);
    check_output("clamp[2]", q_at(2), 255);
    check_output("clamp[3]", q_at(3), 0);
    check_output("clamp[5]", q_at(5), 143);

    // Reset in the middle of a line: outputs drop at once, nothing follows.
    clear_q();
    apply_stimulus(255, 128, 0, 0, 50, 0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle_outputs($sformatf("midreset c%0d", c));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    clear_q();
    repeat (10) tick();
    check_output("after reset de_o", out_q.size(), 0);
    check_output("after reset hs_o", hs_cyc_q.size(), 0);
    run_ramp(make_vec("post_reset", 256, 256, 0, 1, 128));

    // Early hs_i at pixel 100 truncates the line; the next line is intact.
    clear_q();
    apply_stimulus(255, 128, 0, 0, 100, 0);
    apply_stimulus(255, 128, 0, 0, 256, 0);
    repeat (12) tick();
    check_output("early hs count", hs_cyc_q.size(), 2);
    if (hs_mark_q.size() > 1)
      check_output("early truncated count", hs_mark_q[1], 98);
    check_ramp_line("early_new", 98, 128, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
